// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the CPU instruction-fetch port and its data port.
// Latency: request seen in IDLE at cycle T -> m_en at T+1, ack/rdata at T+MEM_LAT+2, next grant decision at T+MEM_LAT+3.
// Backpressure: requesters hold req until their one-cycle ack; data wins ties unless fetch has been passed over STARVE_MAX times.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  // instruction-fetch requester
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  // data requester
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  // memory side
  output logic                m_en,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy
);

  // lat_cnt only ever holds MEM_LAT-1 down to 0
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [LW-1:0] LAT_INIT = LW'(MEM_LAT - 1);
  localparam logic [SW-1:0] SMAX     = SW'(STARVE_MAX);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] ACK   = 2'd3;

  logic [1:0]    state;
  logic [LW-1:0] lat_cnt;
  logic [SW-1:0] starve_cnt;
  logic          gnt_data;    // 1 = current transaction belongs to the data port
  logic          pick_fetch;  // grant decision, meaningful only in IDLE with a request up
  logic          start;       // IDLE with at least one request: a transaction begins this edge
  logic          capture;     // last WAIT cycle: m_rdata is valid now

  // Grant choice: fetch wins when alone or when it has been starved STARVE_MAX times
  always_comb begin
    pick_fetch = 1'b0;
    start      = 1'b0;
    capture    = 1'b0;
    pick_fetch = if_req && (!d_req || (starve_cnt == SMAX));
    start      = (state == IDLE) && (if_req || d_req);
    capture    = (state == WAIT) && (lat_cnt == '0);
  end

  // Sequencer: state, latency counter, starvation counter, m_en strobe and busy flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      gnt_data   <= 1'b0;
      m_en       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // a data grant over a waiting fetch counts as one pass-over; anything else clears it
          if (!if_req || pick_fetch) begin
            starve_cnt <= '0;
          end else if (starve_cnt != SMAX) begin
            starve_cnt <= starve_cnt + SW'(1);
          end
          if (start) begin
            state    <= ISSUE;
            gnt_data <= !pick_fetch;
            m_en     <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ISSUE: begin
          m_en    <= 1'b0;
          lat_cnt <= LAT_INIT;
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            state <= ACK;
          end else begin
            lat_cnt <= lat_cnt - LW'(1);
          end
        end
        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory-side command registers: loaded at the grant, held until the next grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
    end else if (start) begin
      if (pick_fetch) begin
        m_we    <= 1'b0;
        m_addr  <= if_addr;
        m_wdata <= '0;
        m_wstrb <= '0;
      end else begin
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_we ? d_wdata : '0;
        m_wstrb <= d_we ? d_wstrb : '0;
      end
    end
  end

  // Requester-side response registers: one-cycle ack with the captured read word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (capture) begin
      if (gnt_data) begin
        d_ack   <= 1'b1;
        d_rdata <= m_we ? '0 : m_rdata;
      end else begin
        if_ack   <= 1'b1;
        if_rdata <= m_rdata;
      end
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors, multi-cycle corner sequences and a random run against a transaction-level model.
// Latency: the memory model returns mem[addr] exactly LAT cycles after m_en.
// Backpressure: bench requesters hold req and operands until their ack.
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 4;
  localparam int SBW  = DW / 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           if_req, d_req, d_we;
  logic [AW-1:0]  if_addr, d_addr;
  logic [DW-1:0]  d_wdata;
  logic [SBW-1:0] d_wstrb;
  logic           if_ack, d_ack, m_en, m_we, busy;
  logic [DW-1:0]  if_rdata, d_rdata, m_wdata, m_rdata;
  logic [AW-1:0]  m_addr;
  logic [SBW-1:0] m_wstrb;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .busy(busy)
  );

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_init_val(input int i);
    logic [31:0] v;
    v = 32'(i);
    case (i)
      'h040:   return 32'h00500513;  // 0x100
      'h800:   return 32'h11223344;  // 0x2000
      'h801:   return 32'h55667788;  // 0x2004
      'h802:   return 32'h00000000;  // 0x2008
      default: return (v * 32'h9e3779b9) ^ 32'h12345678;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nd, input logic [3:0] strb);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = nd[8*b +: 8];
    return w;
  endfunction

  logic [31:0] dev_mem [0:4095];
  logic [31:0] rd_pipe [LAT];
  logic        mem_ready = 1'b0;

  // Memory device: preload on the first edge, writes on m_en&m_we, read data LAT cycles after m_en
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) dev_mem[i] <= mem_init_val(i);
      mem_ready <= 1'b1;
    end else if (m_en && m_we) begin
      dev_mem[m_addr[13:2]] <= merge(dev_mem[m_addr[13:2]], m_wdata, m_wstrb);
    end
    rd_pipe[0] <= (m_en && !m_we) ? dev_mem[m_addr[13:2]] : 32'hdeaddead;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign m_rdata = rd_pipe[LAT-1];

  // ---------------- checking helpers ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        exp_we;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  // reference memory for the random phase (word index -> value)
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int k;
    k = int'(a[13:2]);
    return ref_mem.exists(k) ? ref_mem[k] : mem_init_val(k);
  endfunction

  function automatic logic [31:0] rnd_addr();
    return 32'h3000 + 32'($urandom_range(0, 7)) * 32'd4;
  endfunction

  // watchdog: every phase is fixed-length, this only guards against a stuck simulator
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    // random-phase model state
    int          next_dec, ack_c, men_c, starve;
    logic        ack_d, gd, fp, dp, dwe, e_we;
    logic [31:0] fa, da, dwd, ack_v, e_addr;
    logic [3:0]  dws, e_wstrb;

    vecs[0] = '{1'b0, 1'b0, 32'h100,  32'h0,        4'h0, 1'b0, 4'h0, 32'h00500513};
    vecs[1] = '{1'b1, 1'b0, 32'h2000, 32'h0,        4'h0, 1'b0, 4'h0, 32'h11223344};
    vecs[2] = '{1'b1, 1'b1, 32'h2004, 32'hdeadbeef, 4'h3, 1'b1, 4'h3, 32'h00000000};
    vecs[3] = '{1'b1, 1'b0, 32'h2004, 32'h0,        4'h0, 1'b0, 4'h0, 32'h5566beef};
    vecs[4] = '{1'b1, 1'b1, 32'h2008, 32'ha1b2c3d4, 4'hc, 1'b1, 4'hc, 32'h00000000};
    vecs[5] = '{1'b0, 1'b0, 32'h2008, 32'h0,        4'h0, 1'b0, 4'h0, 32'ha1b20000};
    vecs[6] = '{1'b1, 1'b0, 32'h100,  32'h12345678, 4'hf, 1'b0, 4'h0, 32'h00500513};
    vecs[7] = '{1'b1, 1'b1, 32'h200c, 32'h0badf00d, 4'hf, 1'b1, 4'hf, 32'h00000000};
    vecs[8] = '{1'b0, 1'b0, 32'h200c, 32'h0,        4'h0, 1'b0, 4'h0, 32'h0badf00d};

    // ---- reset: held 3 cycles, then released with no request ----
    drive_idle();
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_ctrl", 64'({if_ack, d_ack, m_en, m_we, busy}), 64'd0);
    chk("rst_rdata", {if_rdata, d_rdata}, 64'd0);
    chk("rst_maddr_wdata", {m_addr, m_wdata}, 64'd0);
    chk("rst_wstrb", 64'(m_wstrb), 64'd0);
    reset = 1'b1;
    repeat (3) tick();
    chk("idle_ctrl", 64'({if_ack, d_ack, m_en, m_we, busy}), 64'd0);
    chk("idle_maddr", 64'(m_addr), 64'd0);

    // ---- single transactions from the vector table ----
    for (int v = 0; v < 9; v++) begin
      tick();  // cycle 0
      if_req = !vecs[v].is_d; if_addr = vecs[v].addr;
      d_req = vecs[v].is_d; d_we = vecs[v].we; d_addr = vecs[v].addr;
      d_wdata = vecs[v].wdata; d_wstrb = vecs[v].wstrb;
      for (int c = 1; c <= 5; c++) begin
        tick();
        chk("vec_m_en", 64'(m_en), 64'(c == 1));
        chk("vec_busy", 64'(busy), 64'(c <= 4));
        chk("vec_if_ack", 64'(if_ack), 64'(c == 4 && !vecs[v].is_d));
        chk("vec_d_ack", 64'(d_ack), 64'(c == 4 && vecs[v].is_d));
        if (c == 1) begin
          chk("vec_m_addr", 64'(m_addr), 64'(vecs[v].addr));
          chk("vec_m_we", 64'(m_we), 64'(vecs[v].exp_we));
          chk("vec_m_wstrb", 64'(m_wstrb), 64'(vecs[v].exp_wstrb));
          if (vecs[v].exp_we) chk("vec_m_wdata", 64'(m_wdata), 64'(vecs[v].wdata));
        end
        if (c == 4) begin
          chk("vec_rdata", 64'(vecs[v].is_d ? d_rdata : if_rdata), 64'(vecs[v].exp_rdata));
          drive_idle();
        end
      end
    end

    // ---- simultaneous fetch and load: data first, fetch right after ----
    tick();
    if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("sim_d_ack", 64'(d_ack), 64'(c == 4));
      chk("sim_if_ack", 64'(if_ack), 64'(c == 9));
      chk("sim_m_en", 64'(m_en), 64'(c == 1 || c == 6));
      if (c == 4) begin chk("sim_d_rdata", 64'(d_rdata), 64'h11223344); d_req = 1'b0; end
      if (c == 6) chk("sim_fetch_addr", 64'(m_addr), 64'h100);
      if (c == 9) begin chk("sim_if_rdata", 64'(if_rdata), 64'h00500513); if_req = 1'b0; end
    end
    repeat (2) tick();

    // ---- starvation: both held; four data grants, then fetch, then data ----
    tick();
    if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    for (int c = 1; c <= 31; c++) begin
      tick();
      chk("stv_d_ack", 64'(d_ack), 64'(c == 4 || c == 9 || c == 14 || c == 19 || c == 29));
      chk("stv_if_ack", 64'(if_ack), 64'(c == 24));
      if (c == 24) begin chk("stv_if_rdata", 64'(if_rdata), 64'h00500513); if_req = 1'b0; end
      if (c == 29) d_req = 1'b0;
    end
    repeat (2) tick();

    // ---- reset pulsed during WAIT: transaction dropped, restarted after release ----
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    tick();
    chk("rmw_m_en", 64'(m_en), 64'd1);
    tick();  // cycle 2, in WAIT
    reset = 1'b0;
    #1;
    chk("rmw_async_ctrl", 64'({m_en, m_we, busy, if_ack, d_ack}), 64'd0);
    chk("rmw_async_addr", 64'(m_addr), 64'd0);
    #1;
    reset = 1'b1;
    for (int c = 3; c <= 7; c++) begin
      tick();
      chk("rmw_d_ack", 64'(d_ack), 64'(c == 6));
      chk("rmw_m_en", 64'(m_en), 64'(c == 3));
      if (c == 6) begin chk("rmw_d_rdata", 64'(d_rdata), 64'h11223344); d_req = 1'b0; end
    end
    repeat (2) tick();

    // ---- random traffic against a transaction-level model ----
    next_dec = 0; ack_c = -1; men_c = -1; starve = 0;
    ack_d = 1'b0; ack_v = '0; e_addr = '0; e_we = 1'b0; e_wstrb = '0;
    fp = 1'b0; dp = 1'b0; fa = '0; da = '0; dwd = '0; dws = '0; dwe = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      chk("rnd_if_ack", 64'(if_ack), 64'(c == ack_c && !ack_d));
      chk("rnd_d_ack", 64'(d_ack), 64'(c == ack_c && ack_d));
      chk("rnd_m_en", 64'(m_en), 64'(c == men_c));
      if (c == men_c) begin
        chk("rnd_m_addr", 64'(m_addr), 64'(e_addr));
        chk("rnd_m_we", 64'(m_we), 64'(e_we));
        chk("rnd_m_wstrb", 64'(m_wstrb), 64'(e_wstrb));
      end
      if (c == ack_c) begin
        if (ack_d) begin chk("rnd_d_rdata", 64'(d_rdata), 64'(ack_v)); dp = 1'b0; end
        else begin chk("rnd_if_rdata", 64'(if_rdata), 64'(ack_v)); fp = 1'b0; end
      end
      // requesters: start new work when free, hold it until acked
      if (!fp && $urandom_range(0, 1) == 1) begin fp = 1'b1; fa = rnd_addr(); end
      if (!dp && $urandom_range(0, 7) != 0) begin
        dp = 1'b1; dwe = 1'($urandom_range(0, 1)); da = rnd_addr();
        dwd = $urandom; dws = 4'($urandom_range(0, 15));
      end
      if_req = fp; if_addr = fp ? fa : $urandom;
      d_req = dp; d_we = dwe; d_addr = dp ? da : $urandom; d_wdata = dwd; d_wstrb = dws;
      // model: one decision per free slot, each transaction occupies LAT+3 cycles
      if (c == next_dec) begin
        if (!fp && !dp) begin
          starve = 0;
          next_dec = c + 1;
        end else begin
          gd = dp && (!fp || starve < SMAX);
          if (gd && fp) starve = (starve < SMAX) ? starve + 1 : SMAX;
          else starve = 0;
          ack_d = gd;
          men_c = c + 1;
          ack_c = c + LAT + 2;
          next_dec = c + LAT + 3;
          e_addr = gd ? da : fa;
          e_we = gd && dwe;
          e_wstrb = (gd && dwe) ? dws : 4'h0;
          if (gd && dwe) begin
            ref_mem[int'(da[13:2])] = merge(ref_rd(da), dwd, dws);
            ack_v = '0;
          end else begin
            ack_v = ref_rd(e_addr);
          end
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single-port unified memory between the pipelined CPU's instruction-fetch port (IF stage) and its data port (MEM stage).
- Each requester uses a hold-until-ack handshake. Data has fixed priority, with a bounded-starvation override for fetch.
- The memory has a fixed read latency of MEM_LAT cycles.
- The block sits between the CPU core and the memory model, and registers every memory-side and requester-side output.

## Interface

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from m_en to valid m_rdata (≥1)
- STARVE_MAX, 4, consecutive data grants that may pass over a pending fetch (≥1)

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_ack  out  1  one-cycle fetch completion pulse
- if_rdata  out  DATA_W  fetched word, valid with if_ack
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  byte enables for a store
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  DATA_W  load data, valid with d_ack; 0 for stores
- m_en  out  1  one-cycle memory access strobe
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_wstrb  out  DATA_W/8  memory byte enables; 0 on reads
- m_rdata  in  DATA_W  memory read data, valid exactly MEM_LAT cycles after m_en
- busy  out  1  state ≠ IDLE

## Operation

State machine: IDLE → ISSUE → WAIT → ACK → IDLE.

- **IDLE**
  - If neither request is high: stay.
  - Otherwise pick a grant:
    - d_req alone → data.
    - if_req alone → fetch.
    - Both high and starve_cnt == STARVE_MAX → fetch.
    - Both high otherwise → data.
  - Latch the granted address, we, wdata and wstrb into the m_* registers. Go to ISSUE.
- **ISSUE** (cycle E)
  - m_en = 1.
  - m_we/m_addr/m_wdata/m_wstrb are valid and held through ACK.
  - Load lat_cnt = MEM_LAT−1. Go to WAIT.
- **WAIT**
  - Decrement lat_cnt.
  - At the edge that ends cycle E+MEM_LAT, capture m_rdata. The data path uses 0 instead when m_we = 1. Go to ACK.
  - MEM_LAT = 1: WAIT lasts one cycle (E+1) and captures at the end of that cycle.
- **ACK**
  - Pulse the granted requester's x_ack with x_rdata for exactly one cycle.
  - The other requester's ack stays 0.
  - Requester inputs are ignored during ACK. Go to IDLE.
- **Starvation counter** (starve_cnt, width clog2(STARVE_MAX+1)), updated at the IDLE grant decision:
  - Data grant while if_req high → +1, saturating.
  - Fetch grant → 0.
  - IDLE with if_req low → 0.
- **Requester contract**
  - A requester holds req and its inputs stable until ack.
  - It may keep req high after ack to start a new transaction, which is sampled in the following IDLE cycle.
  - The arbiter never samples requester inputs outside IDLE.
- **Reset** (async, any state):
  - State → IDLE; starve_cnt, lat_cnt → 0.
  - All outputs → 0 immediately, including m_en, acks, rdata, m_* and busy.
  - An in-flight transaction is dropped with no ack. The memory response arriving after reset is ignored.

## Timing

- Request first seen high in IDLE at cycle T:
  - m_en at T+1.
  - ack/rdata at T+MEM_LAT+2.
  - Next IDLE at T+MEM_LAT+3.
- Per-transaction occupancy is MEM_LAT+3 cycles. Back-to-back grants are never closer than that.
- x_rdata is valid only in the ack cycle. It may hold its value afterwards, but the bench must not rely on that.
- busy is high from T+1 through the ACK cycle inclusive.

## Test plan

Defaults for all scenarios: MEM_LAT=2, STARVE_MAX=4, memory model returns mem[addr] at E+2.

1. **Reset:** hold reset low 3 cycles → all outputs 0, busy 0. Release with no req → outputs remain 0.
2. **Single fetch:** if_req=1 at cycle 0, if_addr=0x100, mem[0x100]=0x00500513 → m_en=1, m_addr=0x100, m_we=0 at cycle 1; if_ack=1, if_rdata=0x00500513 at cycle 4 only; busy falls at cycle 5.
3. **Simultaneous:** if_req and d_req (load, 0x2000 → 0x11223344) at cycle 0 → d_ack at cycle 4 with 0x11223344; fetch m_en at cycle 6; if_ack at cycle 9.
4. **Store:** d_req, d_we=1, d_addr=0x2004, d_wdata=0xdeadbeef, d_wstrb=0x3 → cycle 1: m_en=1, m_we=1, m_wstrb=0x3, m_wdata=0xdeadbeef; d_ack at cycle 4 with d_rdata=0; memory bytes [1:0] updated.
5. **Starvation:** d_req and if_req held high continuously → four data acks (cycles 4, 9, 14, 19), then the fifth grant goes to fetch (if_ack at cycle 24), then data resumes (d_ack at cycle 29).
6. **Reset mid-WAIT:** single load starting cycle 0; reset pulsed low during cycle 2 → m_* and busy drop to 0 asynchronously; no d_ack ever appears for that transaction. With d_req held after release, the transaction restarts with m_en one cycle after the first IDLE sample.
